// File: rtl/regfile_dbg_if.sv
// Bus bundle for regfile_dbg: two read ports, one strobed write port and the
// handshaked debug scan stream.
interface regfile_dbg_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0]   raddr1;
    logic [ADDR_W-1:0]   raddr2;
    logic [DATA_W-1:0]   rdata1;
    logic [DATA_W-1:0]   rdata2;
    logic                regWrite;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                dbg_start;
    logic                dbg_busy;
    logic                dbg_valid;
    logic                dbg_ready;
    logic [ADDR_W-1:0]   dbg_addr;
    logic [DATA_W-1:0]   dbg_data;
    logic                dbg_done;

    modport master (
        output raddr1, raddr2, regWrite, waddr, wdata, wstrb, dbg_start, dbg_ready,
        input  rdata1, rdata2, dbg_busy, dbg_valid, dbg_addr, dbg_data, dbg_done
    );

    modport slave (
        input  raddr1, raddr2, regWrite, waddr, wdata, wstrb, dbg_start, dbg_ready,
        output rdata1, rdata2, dbg_busy, dbg_valid, dbg_addr, dbg_data, dbg_done
    );
endinterface

// File: rtl/regfile_dbg.sv
// Parametrised register file with write-first bypass, hardwired zero register
// and a handshaked debug scan port that streams every register in order.
//
// state | meaning
// IDLE  | waiting for dbg_start
// SCAN  | presenting beat dbg_addr, advancing on each accepted beat
// DONE  | one-cycle dbg_done pulse after the last beat
module regfile_dbg #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 5,
    parameter int          ZERO_REG = 1,
    parameter logic [31:0] SP_INIT  = 32'h0000_7FFC
) (
    input logic          clk,
    input logic          rst,
    regfile_dbg_if.slave bus
);
    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam int                NBYTES = DATA_W / 8;
    localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_INIT);
    localparam logic [ADDR_W-1:0] LAST   = '1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] stored,
                                                input logic [DATA_W-1:0] wd,
                                                input logic [NBYTES-1:0] strb);
        logic [DATA_W-1:0] r;
        r = stored;
        for (int b = 0; b < NBYTES; b++) begin
            if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Every read port sees the pending write (write-first) so all agree.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a,
                                                    input logic [DATA_W-1:0] stored);
        if (is_zero(a)) return '0;
        if (bus.regWrite && bus.waddr == a) return merge(stored, bus.wdata, bus.wstrb);
        return stored;
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (bus.regWrite && !is_zero(bus.waddr)) begin
            regs_d[bus.waddr] = merge(regs_q[bus.waddr], bus.wdata, bus.wstrb);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == 2) ? SP_RST : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign bus.rdata1   = read_port(bus.raddr1, regs_q[bus.raddr1]);
    assign bus.rdata2   = read_port(bus.raddr2, regs_q[bus.raddr2]);
    assign bus.dbg_data = read_port(cnt_q, regs_q[cnt_q]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.dbg_start) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (bus.dbg_ready) begin
                    if (cnt_q == LAST) state_d = DONE;
                    else               cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bus.dbg_busy  = (state_q != IDLE);
        bus.dbg_valid = (state_q == SCAN);
        bus.dbg_done  = (state_q == DONE);
        bus.dbg_addr  = cnt_q;
    end
endmodule

// File: tb/tb_regfile_dbg.sv
// Self-checking bench for regfile_dbg: directed table, hand-written scan
// sequences and randomized traffic against an array-based reference model.
module tb_regfile_dbg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
    localparam logic [31:0] SP = 32'h0000_7FFC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_dbg_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_dbg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .SP_INIT(SP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m [DEPTH];

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] apply_bytes(input logic [31:0] old, input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Value a reader at address a must see right now.
    function automatic logic [31:0] mrd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (bus.regWrite && bus.waddr == a) return apply_bytes(m[a], bus.wdata, bus.wstrb);
        return m[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) m[i] = (i == 2) ? SP : 32'h0;
        end else if (bus.regWrite && bus.waddr != 0) begin
            m[bus.waddr] = apply_bytes(m[bus.waddr], bus.wdata, bus.wstrb);
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.regWrite  = 1'b0;
        bus.waddr     = '0;
        bus.wdata     = '0;
        bus.wstrb     = '0;
        bus.dbg_start = 1'b0;
        bus.dbg_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    vec_t tbl [10];
    int   beat;
    int   budget;

    initial begin
        for (int i = 0; i < DEPTH; i++) m[i] = 32'hX;
        idle_inputs();
        bus.raddr1 = '0;
        bus.raddr2 = '0;
        // A write presented during reset must be lost.
        bus.regWrite = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF;
        do_reset();
        idle_inputs();
        #2;
        for (int a = 0; a < DEPTH; a++) begin
            bus.raddr1 = 5'(a);
            #1;
            chk($sformatf("reset_x%0d", a), bus.rdata1, (a == 2) ? SP : 32'h0);
        end
        chk("reset_busy",  {31'b0, bus.dbg_busy},  32'h0);
        chk("reset_valid", {31'b0, bus.dbg_valid}, 32'h0);
        chk("reset_done",  {31'b0, bus.dbg_done},  32'h0);
        chk("reset_addr",  {27'b0, bus.dbg_addr},  32'h0);
        tick();

        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 4'hF, 5'd5,  5'd0, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd5,  5'd2, 32'hDEADBEEF, SP};
        tbl[2] = '{1'b1, 5'd0,  32'h12345678, 4'hF, 5'd0,  5'd0, 32'h0,        32'h0};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd0,  5'd5, 32'h0,        32'hDEADBEEF};
        tbl[4] = '{1'b1, 5'd5,  32'h000000AA, 4'h1, 5'd5,  5'd5, 32'hDEADBEAA, 32'hDEADBEAA};
        tbl[5] = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd5,  5'd2, 32'hDEADBEAA, SP};
        tbl[6] = '{1'b1, 5'd2,  32'hAABBCCDD, 4'hA, 5'd2,  5'd3, 32'hAA00CCFC, 32'h0};
        tbl[7] = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd2,  5'd2, 32'hAA00CCFC, 32'hAA00CCFC};
        tbl[8] = '{1'b1, 5'd31, 32'hFFFFFFFF, 4'h0, 5'd31, 5'd7, 32'h0,        32'h0};
        tbl[9] = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd31, 5'd7, 32'h0,        32'h0};
        for (int i = 0; i < 10; i++) begin
            bus.regWrite = tbl[i].we;
            bus.waddr    = tbl[i].waddr;
            bus.wdata    = tbl[i].wdata;
            bus.wstrb    = tbl[i].wstrb;
            bus.raddr1   = tbl[i].ra1;
            bus.raddr2   = tbl[i].ra2;
            #2;
            chk($sformatf("tbl%0d_rdata1", i), bus.rdata1, tbl[i].exp1);
            chk($sformatf("tbl%0d_rdata2", i), bus.rdata2, tbl[i].exp2);
            tick();
        end
        idle_inputs();

        for (int i = 0; i < 300; i++) begin
            bus.regWrite = 1'($urandom_range(0, 1));
            bus.waddr    = 5'($urandom_range(0, 31));
            bus.wdata    = $urandom;
            bus.wstrb    = 4'($urandom_range(0, 15));
            bus.raddr1   = ($urandom_range(0, 3) == 0) ? bus.waddr : 5'($urandom_range(0, 31));
            bus.raddr2   = 5'($urandom_range(0, 31));
            #2;
            chk("rand_rdata1", bus.rdata1, mrd(bus.raddr1));
            chk("rand_rdata2", bus.rdata2, mrd(bus.raddr2));
            tick();
        end
        idle_inputs();

        // Full scan with ready held high; a second start mid-scan is ignored.
        bus.dbg_start = 1'b1;
        tick();
        bus.dbg_start = 1'b0;
        for (beat = 0; beat < DEPTH; beat++) begin
            bus.dbg_start = (beat == 5 || beat == 20);
            #2;
            chk("scan_busy",  {31'b0, bus.dbg_busy},  32'h1);
            chk("scan_valid", {31'b0, bus.dbg_valid}, 32'h1);
            chk("scan_addr",  {27'b0, bus.dbg_addr},  32'(beat));
            chk("scan_data",  bus.dbg_data, mrd(5'(beat)));
            tick();
        end
        bus.dbg_start = 1'b0;
        #2;
        chk("scan_done_pulse", {31'b0, bus.dbg_done},  32'h1);
        chk("scan_done_busy",  {31'b0, bus.dbg_busy},  32'h1);
        chk("scan_done_valid", {31'b0, bus.dbg_valid}, 32'h0);
        tick();
        #2;
        chk("post_done", {31'b0, bus.dbg_done}, 32'h0);
        chk("post_busy", {31'b0, bus.dbg_busy}, 32'h0);
        tick();

        // Backpressure with a concurrent write to the stalled register.
        bus.dbg_start = 1'b1;
        tick();
        bus.dbg_start = 1'b0;
        tick(); tick(); tick();
        bus.dbg_ready = 1'b0;
        bus.regWrite = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h55; bus.wstrb = 4'hF;
        #2;
        chk("bp_addr_bypass", {27'b0, bus.dbg_addr}, 32'd3);
        chk("bp_data_bypass", bus.dbg_data, 32'h55);
        tick();
        bus.regWrite = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("bp_hold_addr",  {27'b0, bus.dbg_addr},  32'd3);
            chk("bp_hold_valid", {31'b0, bus.dbg_valid}, 32'h1);
            chk("bp_hold_data",  bus.dbg_data, 32'h55);
            tick();
        end
        bus.dbg_ready = 1'b1;
        #2;
        chk("bp_xfer_data", bus.dbg_data, 32'h55);
        tick();
        #2;
        chk("bp_advance", {27'b0, bus.dbg_addr}, 32'd4);
        // Finish with random ready and random writes.
        beat = 4;
        budget = 400;
        while (!bus.dbg_done && budget > 0) begin
            bus.dbg_ready = 1'($urandom_range(0, 1));
            bus.regWrite  = 1'($urandom_range(0, 1));
            bus.waddr     = 5'($urandom_range(0, 31));
            bus.wdata     = $urandom;
            bus.wstrb     = 4'($urandom_range(0, 15));
            #2;
            chk("rs_valid", {31'b0, bus.dbg_valid}, 32'h1);
            chk("rs_addr",  {27'b0, bus.dbg_addr},  32'(beat));
            chk("rs_data",  bus.dbg_data, mrd(5'(beat)));
            if (bus.dbg_ready) beat++;
            tick();
            budget--;
        end
        idle_inputs();
        chk("rs_beats", 32'(beat), 32'(DEPTH));
        chk("rs_done_seen", {31'b0, bus.dbg_done}, 32'h1);
        tick();
        tick();

        // Reset mid-scan aborts without dbg_done and a new start restarts at 0.
        bus.dbg_start = 1'b1;
        tick();
        bus.dbg_start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        #2;
        chk("mid_addr10", {27'b0, bus.dbg_addr}, 32'd10);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("abort_busy",  {31'b0, bus.dbg_busy},  32'h0);
            chk("abort_valid", {31'b0, bus.dbg_valid}, 32'h0);
            chk("abort_done",  {31'b0, bus.dbg_done},  32'h0);
            chk("abort_addr",  {27'b0, bus.dbg_addr},  32'h0);
            tick();
        end
        bus.raddr1 = 5'd5;
        bus.raddr2 = 5'd2;
        #2;
        chk("abort_x5_cleared", bus.rdata1, 32'h0);
        chk("abort_sp",         bus.rdata2, SP);
        bus.dbg_start = 1'b1;
        tick();
        bus.dbg_start = 1'b0;
        #2;
        chk("restart_valid", {31'b0, bus.dbg_valid}, 32'h1);
        chk("restart_addr",  {27'b0, bus.dbg_addr},  32'h0);
        tick();
        #2;
        chk("restart_addr1", {27'b0, bus.dbg_addr}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
